sha_digest_serializer: RTL and testbench
========================================

Name: sha_digest_serializer

Overview:
- Sink for the digest output of the SHA cores (ivalid/iid/ilen/isha, a one-cycle pulse with no backpressure).
- Buffers digests in a small FIFO.
- Re-emits each digest as a byte stream with valid/ready/last/id, in the same style as the cores' input stream.
- Sits between a SHA core and a UART/DMA byte sink.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
DIGEST_BYTES, 64, digest width in bytes (32 for SHA-256, 64 for SHA-512).

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
ivalid  in  1  digest valid pulse, no backpressure
iid  in  32  message id
ilen  in  61  message length in bytes
isha  in  DIGEST_BYTES*8  digest; MSB byte first
mvalid  out  1  output byte valid
mready  in  1  downstream ready
mlast  out  1  last byte of record
mid  out  32  record id on first byte of record, 0 otherwise
mdata  out  8  output byte
drop_cnt  out  16  saturating count of digests dropped on full FIFO
fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values (rstn=0 at a clk edge): mvalid=0, mlast=0, mid=0, mdata=0, drop_cnt=0, fifo_level=0. FIFO is emptied. FSM goes to IDLE.
- Reset mid-record discards the partial record. The next record starts at byte 0.
- FIFO write: ivalid=1 stores {iid, ilen, isha}.
  - Accepted if FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the digest is dropped and drop_cnt increments, saturating at 0xFFFF.
- FIFO: pointers wrap modulo DEPTH. fifo_level counts 0..DEPTH.
- FSM IDLE: if FIFO is non-empty, pop the head into a shift register, clear the byte counter, go to SEND. The outputs register mvalid=1 with byte 0 in the following cycle.
- FSM SEND: a byte is transferred when mvalid&&mready.
  - On transfer: shift to the next byte and increment the counter.
  - On transfer of the last byte, if the FIFO is non-empty, pop and load the next record. Byte 0 appears in the next cycle with no bubble. Otherwise return to IDLE with mvalid=0.
- Latency: ivalid sampled at edge N into an empty, idle block gives mvalid=1 after edge N+1.
- Byte order: isha[8*DIGEST_BYTES-1 -: 8] first, isha[7:0] last.
- mid = stored iid on byte 0 only, else 0.
- mlast=1 only on the final byte of a record.
- Stability: while mvalid=1 and mready=0, mvalid, mdata, mid and mlast hold constant.
- mvalid does not depend combinationally on mready.
- Capacity: DEPTH FIFO entries plus 1 record in the shift register.
- ilen is carried but not emitted unless the optional feature is enabled.

Optional Feature:
- Macro: SHA_SER_HEADER_EN.
- Defined: each record is prefixed by a 12-byte header before the digest bytes:
  - iid as 4 bytes, big-endian;
  - ilen zero-extended to 64 bits as 8 bytes, big-endian.
  - Record length is 12+DIGEST_BYTES. mid is presented on the first header byte. mlast is on the final digest byte.
- Undefined: the record is the digest bytes only. ilen need not be stored in the FIFO.

Test Plan:
- Single digest: ivalid, iid=111, ilen=3, isha=SHA-512("abc") (ddaf35a1...a54ca49f), mready=1 -> 64 consecutive bytes. Byte 0=0xDD with mid=111. Byte 63=0x9F with mlast=1. mvalid rises 2 edges after ivalid.
- Backpressure: same record, mready random at 20% high -> identical byte sequence. Outputs are stable on every stalled cycle.
- Overflow: DEPTH=4, mready=0, 7 ivalid pulses on consecutive cycles -> 5 accepted, drop_cnt=2, fifo_level=4. Then mready=1 -> 5 records delivered in order, fifo_level reaches 0.
- Back-to-back: ids 1 and 2 written 1 cycle apart, mready=1 -> 128 consecutive mvalid cycles with no bubble. mid=1 at byte 0, mid=2 at byte 64, mlast at bytes 63 and 127.
- Reset mid-record: rstn=0 for 1 cycle after 10 bytes sent -> mvalid=0, fifo_level=0, drop_cnt=0 after that edge. A new digest then starts cleanly at byte 0 with its mid.
- SHA_SER_HEADER_EN defined: iid=0x6F, ilen=3, "abc" digest -> bytes 00 00 00 6F 00 00 00 00 00 00 00 03 DD AF ... 9F. mid=0x6F on byte 0, mlast on byte 75.

Source files
------------

// File: rtl/sha_digest_serializer.sv
// rtl/sha_digest_serializer.sv - buffers SHA digests in a FIFO and re-emits each one as a byte stream
//
// Optional build macro: SHA_SER_HEADER_EN
//   When defined, each record starts with a 12-byte header:
//   iid (4 bytes, big-endian), then ilen zero-extended to 64 bits (8 bytes, big-endian).
//
// Ports:
//   clk        clock
//   rstn       synchronous reset, active-low
//   ivalid     digest valid pulse (no backpressure)
//   iid        message id
//   ilen       message length in bytes
//   isha       digest, MSB byte first
//   mvalid     output byte valid
//   mready     downstream ready
//   mlast      last byte of record
//   mid        record id on the first byte of a record, 0 otherwise
//   mdata      output byte
//   drop_cnt   saturating count of digests dropped on a full FIFO
//   fifo_level FIFO occupancy, 0..DEPTH
module sha_digest_serializer #(
  parameter int DEPTH        = 4,
  parameter int DIGEST_BYTES = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ivalid,
  input  logic [31:0]               iid,
  input  logic [60:0]               ilen,
  input  logic [DIGEST_BYTES*8-1:0] isha,
  output logic                      mvalid,
  input  logic                      mready,
  output logic                      mlast,
  output logic [31:0]               mid,
  output logic [7:0]                mdata,
  output logic [15:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = DIGEST_BYTES * 8;
`ifdef SHA_SER_HEADER_EN
  localparam int HDR_BYTES = 12;
  localparam int EW        = 32 + 61 + DW;
`else
  localparam int HDR_BYTES = 0;
  localparam int EW        = 32 + DW;
`endif
  localparam int REC_BYTES = HDR_BYTES + DIGEST_BYTES;
  localparam int RW        = REC_BYTES * 8;
  localparam int CW        = $clog2(REC_BYTES);

  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(REC_BYTES - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_next;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [RW-1:0] head_rec;
  logic [31:0]   head_id;

  logic [RW-1:0] sreg;
  logic [CW-1:0] byte_cnt;

  logic empty, full, push, pop, xfer, at_last;

  assign empty   = (count == '0);
  assign full    = (count == LEVEL_FULL);
  assign xfer    = (state == SEND) && mready;
  assign at_last = (byte_cnt == LAST_IDX);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = ivalid && (!full || pop);

  assign head    = mem[rd_ptr];
  assign head_id = head[EW-1 -: 32];

`ifdef SHA_SER_HEADER_EN
  assign wr_entry = {iid, ilen, isha};
  assign head_rec = {head_id, 3'b000, head[DW+60:DW], head[DW-1:0]};
`else
  logic unused_ilen;
  assign unused_ilen = ^ilen;
  assign wr_entry    = {iid, isha};
  assign head_rec    = head[DW-1:0];
`endif

  // FSM: IDLE loads the head record; SEND streams it and chains straight
  // into the next record on the final byte so there is no bubble.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (mready && at_last) begin
          if (!empty) pop        = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage has no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ivalid && !push && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Output shift register: the top byte is always the byte on offer.
  // Zeros are shifted in, so after the final byte mdata naturally reads 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sreg     <= '0;
      mid      <= '0;
      byte_cnt <= '0;
    end else if (pop) begin
      sreg     <= head_rec;
      mid      <= head_id;
      byte_cnt <= '0;
    end else if (xfer) begin
      sreg     <= {sreg[RW-9:0], 8'h00};
      mid      <= '0;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign mvalid     = (state == SEND);
  assign mlast      = mvalid && at_last;
  assign mdata      = sreg[RW-1 -: 8];
  assign fifo_level = count;

endmodule

// File: tb/tb_sha_digest_serializer.sv
// tb/tb_sha_digest_serializer.sv - scoreboard bench for sha_digest_serializer
module tb_sha_digest_serializer;

  localparam int DEPTH        = 4;
  localparam int DIGEST_BYTES = 64;
  localparam int DW           = DIGEST_BYTES * 8;
`ifdef SHA_SER_HEADER_EN
  localparam int REC = 12 + DIGEST_BYTES;
`else
  localparam int REC = DIGEST_BYTES;
`endif

  localparam logic [DW-1:0] ABC = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   ivalid = 1'b0;
  logic [31:0]            iid = '0;
  logic [60:0]            ilen = '0;
  logic [DW-1:0]          isha = '0;
  logic                   mvalid;
  logic                   mready = 1'b0;
  logic                   mlast;
  logic [31:0]            mid;
  logic [7:0]             mdata;
  logic [15:0]            drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  sha_digest_serializer #(.DEPTH(DEPTH), .DIGEST_BYTES(DIGEST_BYTES)) dut (
    .clk(clk), .rstn(rstn), .ivalid(ivalid), .iid(iid), .ilen(ilen), .isha(isha),
    .mvalid(mvalid), .mready(mready), .mlast(mlast), .mid(mid), .mdata(mdata),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] id;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int issued = 0;
  int done_recs = 0;
  int ready_pct = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: a record is an optional header then the digest, each field big-endian.
  function automatic logic [7:0] ref_byte(input logic [31:0] id, input logic [60:0] len,
                                          input logic [DW-1:0] sha, input int k);
    int kk;
    logic [63:0] len64;
    kk = k;
    len64 = {3'b000, len};
`ifdef SHA_SER_HEADER_EN
    if (kk < 4) return 8'(id >> (8 * (3 - kk)));
    if (kk < 12) return 8'(len64 >> (8 * (11 - kk)));
    kk = kk - 12;
`endif
    if (len64 == 64'hFFFF_FFFF_FFFF_FFFF) kk = kk; // keeps len64 referenced in both builds
    return 8'(sha >> (8 * (DIGEST_BYTES - 1 - kk)));
  endfunction

  function automatic logic [DW-1:0] rand_sha();
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < DW / 32; i++) s[i*32 +: 32] = $urandom();
    return s;
  endfunction

  task automatic model_push(input logic [31:0] id, input logic [60:0] len, input logic [DW-1:0] sha);
    exp_t e;
    for (int k = 0; k < REC; k++) begin
      e.data = ref_byte(id, len, sha, k);
      e.id   = (k == 0) ? id : 32'h0;
      e.last = (k == REC - 1);
      sb.push_back(e);
    end
    issued++;
  endtask

  // Called at posedge+1; ivalid is sampled on the following edge.
  task automatic drive_digest(input logic [31:0] id, input logic [60:0] len,
                              input logic [DW-1:0] sha, input bit accept);
    ivalid = 1'b1;
    iid    = id;
    ilen   = len;
    isha   = sha;
    if (accept) model_push(id, len, sha);
    @(posedge clk);
    #1;
    ivalid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input int budget);
    int c;
    c = 0;
    while ((issued - done_recs) >= DEPTH && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (c >= budget) check("slot_timeout", 64'(issued - done_recs), 64'(DEPTH - 1));
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #2;
      mready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic monitor();
    bit         have_stall;
    logic [7:0] s_data;
    logic [31:0] s_id;
    logic       s_last;
    exp_t       e;
    have_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        have_stall = 1'b0;
        continue;
      end
      if (have_stall)
        check("stall_hold", {23'd0, mvalid, mdata, mid, mlast},
              {23'd0, 1'b1, s_data, s_id, s_last});
      if (mvalid === 1'b1 && mready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", mdata);
        end else begin
          e = sb.pop_front();
          check("mdata", 64'(mdata), 64'(e.data));
          check("mid", 64'(mid), 64'(e.id));
          check("mlast", 64'(mlast), 64'(e.last));
          if (e.last) done_recs++;
        end
      end
      have_stall = (mvalid === 1'b1 && mready === 1'b0);
      s_data = mdata;
      s_id   = mid;
      s_last = mlast;
    end
  endtask

  initial begin
    int idx;
    bit found;
    int run;
    logic [DW-1:0] sha;
    logic [31:0] id;
    logic [60:0] len;

    fork
      monitor();
      ready_driver();
    join_none

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", 64'(mvalid), 64'd0);
    check("rst_mlast", 64'(mlast), 64'd0);
    check("rst_mid", 64'(mid), 64'd0);
    check("rst_mdata", 64'(mdata), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    rstn = 1'b1;

    // Single "abc" digest with mready held high; latency and framing
    ready_pct = 100;
    repeat (3) @(posedge clk);
    #1;
    drive_digest(32'd111, 61'd3, ABC, 1'b1);
    check("lat_edge_n", 64'(mvalid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_edge_n1", 64'(mvalid), 64'd1);
    check("byte0_mdata", 64'(mdata), 64'(ref_byte(32'd111, 61'd3, ABC, 0)));
    check("byte0_mid", 64'(mid), 64'd111);
    idx = 0;
    found = 1'b0;
    for (int c = 0; c < REC + 10; c++) begin
      @(negedge clk);
      if (mvalid && mlast) begin
        found = 1'b1;
        break;
      end
      idx++;
    end
    check("last_found", 64'(found), 64'd1);
    check("last_index", 64'(idx), 64'(REC - 1));
    check("last_mdata", 64'(mdata), 64'h9F);
    wait_drain("drain_single", 200);

    // Same record under 20% ready
    ready_pct = 20;
    drive_digest(32'd111, 61'd3, ABC, 1'b1);
    wait_drain("drain_backpressure", 3000);

    // Overflow: capacity is DEPTH in the FIFO plus one in the shifter
    ready_pct = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++)
      drive_digest(32'd100 + 32'(i), 61'(i), rand_sha(), (i < DEPTH + 1));
    check("ovf_drop_cnt", 64'(drop_cnt), 64'(7 - (DEPTH + 1)));
    check("ovf_fifo_level", 64'(fifo_level), 64'(DEPTH));
    ready_pct = 100;
    wait_drain("drain_overflow", 2000);
    check("ovf_level_empty", 64'(fifo_level), 64'd0);

    // Back-to-back records: no bubble between them
    drive_digest(32'd1, 61'd10, rand_sha(), 1'b1);
    drive_digest(32'd2, 61'd20, rand_sha(), 1'b1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mvalid) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b_start", 64'(found), 64'd1);
    run = 0;
    while (mvalid && run < 3 * REC) begin
      run++;
      @(negedge clk);
    end
    check("b2b_run", 64'(run), 64'(2 * REC));
    wait_drain("drain_b2b", 200);

    // Reset after 10 bytes of a record
    drive_digest(32'h55, 61'd7, rand_sha(), 1'b1);
    idx = 0;
    for (int c = 0; c < 100 && idx < 10; c++) begin
      @(negedge clk);
      if (mvalid && mready) idx++;
    end
    check("rst_mid_bytes", 64'(idx), 64'd10);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    sb.delete();
    issued = done_recs;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst2_mvalid", 64'(mvalid), 64'd0);
    check("rst2_fifo_level", 64'(fifo_level), 64'd0);
    check("rst2_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst2_mid", 64'(mid), 64'd0);
    sha = rand_sha();
    drive_digest(32'h77, 61'd9, sha, 1'b1);
    @(posedge clk);
    #1;
    check("rst2_new_mvalid", 64'(mvalid), 64'd1);
    check("rst2_new_mid", 64'(mid), 64'h77);
    check("rst2_new_byte0", 64'(mdata), 64'(ref_byte(32'h77, 61'd9, sha, 0)));
    wait_drain("drain_after_reset", 200);

    // Randomized traffic with random ready
    ready_pct = 50;
    for (int r = 0; r < 8; r++) begin
      wait_slot(2000);
      repeat ($urandom_range(20)) @(posedge clk);
      #1;
      id  = $urandom();
      len = 61'({$urandom(), $urandom()});
      drive_digest(id, len, rand_sha(), 1'b1);
    end
    wait_drain("drain_random", 5000);
    check("final_level", 64'(fifo_level), 64'd0);
    check("final_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
